// File: rtl/prefetch_scfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prefetch_scfifo                                               |
// | Desc     : Single-clock show-ahead FIFO. A small register prefetch stage |
// |            sits in front of a block-RAM store so rd_data/rd_valid come   |
// |            straight from flops and reads sustain one word per clock.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prefetch_scfifo #(
   parameter int DATA_BITS    = 8,
   parameter int ADDR_BITS    = 6,
   parameter int PREFETCH     = 3,
   parameter int ZERO_LATENCY = 0,
   parameter int ALMOST_FULL  = 3 * (2 ** ADDR_BITS) / 4,
   parameter int ALMOST_EMPTY = (2 ** ADDR_BITS) / 4
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic [ADDR_BITS:0]   used,
   output logic                 full,
   output logic                 alfull,
   output logic                 alempty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int c_depth = 2 ** ADDR_BITS;
   localparam int c_cw    = ADDR_BITS + 1;
   localparam int c_pw    = $clog2(PREFETCH + 1);

   // Storage (no reset: contents are qualified by the counters)
   logic [DATA_BITS-1:0] mem_q       [c_depth];
   logic [DATA_BITS-1:0] ram_rdata_q;
   logic [DATA_BITS-1:0] pf_data_q   [PREFETCH];
   logic [DATA_BITS-1:0] pf_data_d   [PREFETCH];

   // Control state
   logic [c_pw-1:0]      pf_cnt_q, pf_cnt_d;
   logic                 inflight_q, inflight_d;
   logic [ADDR_BITS-1:0] wadd_q, wadd_d;
   logic [ADDR_BITS-1:0] raddr_q, raddr_d;
   logic [c_cw-1:0]      ram_cnt_q, ram_cnt_d;
   logic [c_cw-1:0]      used_q, used_d;
   logic                 full_q, full_d;
   logic                 alfull_q, alfull_d;
   logic                 alempty_q, alempty_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   // Request decode
   logic                 w_pf_valid;
   logic                 w_bypass;
   logic                 w_pass_thru;
   logic                 w_rd_pop;
   logic                 w_wr_acc;
   logic                 w_wr_to_pf;
   logic                 w_wr_to_ram;
   logic                 w_issue;
   logic                 w_push;
   logic [c_pw-1:0]      w_pf_after_pop;
   logic [DATA_BITS-1:0] w_push_data;

   // Decode accepted reads/writes and route writes to prefetch stage or RAM
   always_comb begin
      w_pf_valid     = (pf_cnt_q != '0);
      w_bypass       = (ZERO_LATENCY != 0) && !w_pf_valid && wr_en && !flush;
      w_pass_thru    = w_bypass && rd_en;
      w_rd_pop       = rd_en && w_pf_valid && !flush;
      w_wr_acc       = wr_en && !flush && (!full_q || rd_en) && !w_pass_thru;
      w_pf_after_pop = pf_cnt_q - c_pw'(w_rd_pop);
      // A write may only bypass the RAM if nothing older is still in there
      w_wr_to_pf     = w_wr_acc && (ram_cnt_q == '0) && !inflight_q
                       && (int'(w_pf_after_pop) < PREFETCH);
      w_wr_to_ram    = w_wr_acc && !w_wr_to_pf;
      // Refill counts the slot freed by this cycle's pop so reads never bubble
      w_issue        = !flush && (ram_cnt_q != '0)
                       && ((int'(w_pf_after_pop) + int'(inflight_q)) < PREFETCH);
      // Landing RAM data and a direct write never coincide (write needs !inflight)
      w_push         = inflight_q || w_wr_to_pf;
      w_push_data    = inflight_q ? ram_rdata_q : wr_data;
   end

   // Next-state for prefetch shifter, pointers, counters and flags
   always_comb begin
      pf_data_d = pf_data_q;
      if (w_rd_pop) begin
         for (int i = 0; i < PREFETCH - 1; i++) begin
            pf_data_d[i] = pf_data_q[i+1];
         end
      end
      if (w_push) begin
         for (int i = 0; i < PREFETCH; i++) begin
            if (c_pw'(i) == w_pf_after_pop) begin
               pf_data_d[i] = w_push_data;
            end
         end
      end
      pf_cnt_d    = w_pf_after_pop + c_pw'(w_push);
      inflight_d  = w_issue;
      wadd_d      = wadd_q + ADDR_BITS'(w_wr_to_ram);
      raddr_d     = raddr_q + ADDR_BITS'(w_issue);
      ram_cnt_d   = ram_cnt_q + c_cw'(w_wr_to_ram) - c_cw'(w_issue);
      used_d      = used_q + c_cw'(w_wr_acc) - c_cw'(w_rd_pop);
      overflow_d  = overflow_q || (wr_en && full_q && !rd_en && !flush);
      underflow_d = underflow_q || (rd_en && !rd_valid && !flush);
      if (flush) begin
         pf_cnt_d   = '0;
         inflight_d = 1'b0;
         wadd_d     = '0;
         raddr_d    = '0;
         ram_cnt_d  = '0;
         used_d     = '0;
      end
      full_d    = (used_d == c_cw'(c_depth));
      alfull_d  = (int'(used_q) >= ALMOST_FULL);
      alempty_d = (int'(used_q) <= ALMOST_EMPTY);
   end

   // RAM write port and registered read port, plus prefetch data registers
   always_ff @(posedge clk) begin
      if (w_wr_to_ram) begin
         mem_q[wadd_q] <= wr_data;
      end
      if (w_issue) begin
         ram_rdata_q <= mem_q[raddr_q];
      end
      pf_data_q <= pf_data_d;
   end

   // Control registers; srst overrides flush and clears sticky flags too
   always_ff @(posedge clk) begin
      if (srst) begin
         pf_cnt_q    <= '0;
         inflight_q  <= 1'b0;
         wadd_q      <= '0;
         raddr_q     <= '0;
         ram_cnt_q   <= '0;
         used_q      <= '0;
         full_q      <= 1'b0;
         alfull_q    <= 1'b0;
         alempty_q   <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pf_cnt_q    <= pf_cnt_d;
         inflight_q  <= inflight_d;
         wadd_q      <= wadd_d;
         raddr_q     <= raddr_d;
         ram_cnt_q   <= ram_cnt_d;
         used_q      <= used_d;
         full_q      <= full_d;
         alfull_q    <= alfull_d;
         alempty_q   <= alempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Simulation-only consistency between counters and head-valid state
   always_ff @(posedge clk) begin
      if (!srst) begin
         assert (full_q == (used_q == c_cw'(c_depth)));
         assert (w_pf_valid == (used_q != '0));
      end
   end

   assign rd_valid  = w_pf_valid || w_bypass;
   assign rd_data   = w_bypass ? wr_data : pf_data_q[0];
   assign used      = used_q;
   assign full      = full_q;
   assign alfull    = alfull_q;
   assign alempty   = alempty_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_scfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prefetch_scfifo                                            |
// | Desc     : Directed bench for prefetch_scfifo: one registered-output     |
// |            instance and one zero-latency bypass instance, DEPTH 16.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_prefetch_scfifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: ZERO_LATENCY = 0
   logic       a_srst, a_flush, a_wr_en, a_rd_en;
   logic [7:0] a_wr_data, a_rd_data;
   logic       a_rd_valid, a_full, a_alfull, a_alempty, a_overflow, a_underflow;
   logic [4:0] a_used;

   // Instance B: ZERO_LATENCY = 1
   logic       b_srst, b_flush, b_wr_en, b_rd_en;
   logic [7:0] b_wr_data, b_rd_data;
   logic       b_rd_valid, b_full, b_alfull, b_alempty, b_overflow, b_underflow;
   logic [4:0] b_used;

   prefetch_scfifo #(
      .DATA_BITS(8), .ADDR_BITS(4), .PREFETCH(3), .ZERO_LATENCY(0),
      .ALMOST_FULL(12), .ALMOST_EMPTY(4)
   ) u_dut_a (
      .clk(clk), .srst(a_srst), .flush(a_flush),
      .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .used(a_used),
      .full(a_full), .alfull(a_alfull), .alempty(a_alempty),
      .overflow(a_overflow), .underflow(a_underflow)
   );

   prefetch_scfifo #(
      .DATA_BITS(8), .ADDR_BITS(4), .PREFETCH(3), .ZERO_LATENCY(1),
      .ALMOST_FULL(12), .ALMOST_EMPTY(4)
   ) u_dut_b (
      .clk(clk), .srst(b_srst), .flush(b_flush),
      .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .used(b_used),
      .full(b_full), .alfull(b_alfull), .alempty(b_alempty),
      .overflow(b_overflow), .underflow(b_underflow)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // Single comparison point: counts every vector, reports any mismatch
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] model_q[$];
   int         prev_size;
   logic       wr, rd, wr_ok;
   logic [7:0] wdat;
   int         pw;

   initial begin
      a_srst = 1'b1; a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
      b_srst = 1'b1; b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
      tick();
      tick();
      a_srst = 1'b0;
      b_srst = 1'b0;

      // Reset values
      check_val("rst_used",      a_used, 0);
      check_val("rst_valid",     a_rd_valid, 0);
      check_val("rst_full",      a_full, 0);
      check_val("rst_alfull",    a_alfull, 0);
      check_val("rst_alempty",   a_alempty, 1);
      check_val("rst_overflow",  a_overflow, 0);
      check_val("rst_underflow", a_underflow, 0);

      // Fill 0x01..0x10; first word visible one cycle after its write
      for (int i = 1; i <= 16; i++) begin
         a_wr_en = 1'b1;
         a_wr_data = 8'(i);
         tick();
         if (i == 1) begin
            check_val("first_valid", a_rd_valid, 1);
            check_val("first_data",  a_rd_data, 8'h01);
         end
      end
      a_wr_en = 1'b0;
      check_val("fill_full",    a_full, 1);
      check_val("fill_used",    a_used, 16);
      check_val("fill_alfull",  a_alfull, 1);
      check_val("fill_alempty", a_alempty, 0);
      check_val("fill_ovf",     a_overflow, 0);

      // 17th word while full is dropped
      a_wr_en = 1'b1; a_wr_data = 8'h11;
      tick();
      a_wr_en = 1'b0;
      check_val("ovf_flag", a_overflow, 1);
      check_val("ovf_used", a_used, 16);

      // Write and read together while full
      a_wr_en = 1'b1; a_wr_data = 8'h11; a_rd_en = 1'b1;
      check_val("wrrd_head", a_rd_data, 8'h01);
      tick();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      check_val("wrrd_used", a_used, 16);
      check_val("wrrd_full", a_full, 1);
      check_val("wrrd_next", a_rd_data, 8'h02);

      // Continuous drain: 0x02..0x11 on consecutive cycles
      a_rd_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check_val("drain_valid", a_rd_valid, 1);
         check_val("drain_data",  a_rd_data, 8'(k + 2));
         tick();
      end
      a_rd_en = 1'b0;
      check_val("drain_used",    a_used, 0);
      check_val("drain_valid0",  a_rd_valid, 0);
      check_val("drain_full",    a_full, 0);
      check_val("drain_alempty", a_alempty, 1);
      check_val("drain_udf",     a_underflow, 0);
      check_val("drain_ovf",     a_overflow, 1);

      // Read on empty
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      check_val("udf_flag", a_underflow, 1);
      check_val("udf_used", a_used, 0);

      // Fill 8, pop one (starts a refill read), flush while it is in flight
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1'b1;
         a_wr_data = 8'(8'h40 + i);
         tick();
      end
      a_wr_en = 1'b0;
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      check_val("flush_valid", a_rd_valid, 0);
      check_val("flush_used",  a_used, 0);
      check_val("flush_full",  a_full, 0);
      check_val("flush_ovf",   a_overflow, 1);
      check_val("flush_udf",   a_underflow, 1);
      a_wr_en = 1'b1; a_wr_data = 8'h3C;
      tick();
      a_wr_en = 1'b0;
      check_val("post_flush_valid", a_rd_valid, 1);
      check_val("post_flush_data",  a_rd_data, 8'h3C);
      check_val("post_flush_used",  a_used, 1);
      tick();
      check_val("post_flush_hold", a_rd_data, 8'h3C);
      check_val("post_flush_used2", a_used, 1);

      // Random traffic against a queue model; fill-biased then drain-biased
      model_q.delete();
      model_q.push_back(8'h3C);
      prev_size = 1;
      for (int n = 0; n < 2000; n++) begin
         pw = (n < 1000) ? 70 : 30;
         check_val("rnd_valid", a_rd_valid, (model_q.size() != 0) ? 1 : 0);
         if (model_q.size() != 0) begin
            check_val("rnd_data", a_rd_data, model_q[0]);
         end
         check_val("rnd_used",    a_used, model_q.size());
         check_val("rnd_full",    a_full, (model_q.size() == 16) ? 1 : 0);
         check_val("rnd_alfull",  a_alfull, (prev_size >= 12) ? 1 : 0);
         check_val("rnd_alempty", a_alempty, (prev_size <= 4) ? 1 : 0);
         wr   = ($urandom_range(99) < pw);
         rd   = ($urandom_range(99) < 50);
         wdat = 8'($urandom_range(255));
         a_wr_en = wr; a_wr_data = wdat; a_rd_en = rd;
         prev_size = model_q.size();
         wr_ok = wr && ((model_q.size() < 16) || rd);
         if (rd && model_q.size() != 0) begin
            void'(model_q.pop_front());
         end
         if (wr_ok) begin
            model_q.push_back(wdat);
         end
         tick();
      end
      a_wr_en = 1'b0; a_rd_en = 1'b0;

      // Flush, fill 5 with overflow still set, then srst clears everything
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_wr_en = 1'b1;
         a_wr_data = 8'(8'h70 + i);
         tick();
      end
      a_wr_en = 1'b0;
      check_val("pre_srst_used", a_used, 5);
      check_val("pre_srst_ovf",  a_overflow, 1);
      a_srst = 1'b1;
      tick();
      a_srst = 1'b0;
      check_val("srst_used",    a_used, 0);
      check_val("srst_valid",   a_rd_valid, 0);
      check_val("srst_full",    a_full, 0);
      check_val("srst_alfull",  a_alfull, 0);
      check_val("srst_alempty", a_alempty, 1);
      check_val("srst_ovf",     a_overflow, 0);
      check_val("srst_udf",     a_underflow, 0);

      // Zero-latency instance: pass-through on empty with simultaneous read
      b_wr_en = 1'b1; b_wr_data = 8'hA5; b_rd_en = 1'b1;
      #1;
      check_val("zl_pass_valid", b_rd_valid, 1);
      check_val("zl_pass_data",  b_rd_data, 8'hA5);
      tick();
      b_wr_en = 1'b0; b_rd_en = 1'b0;
      #1;
      check_val("zl_pass_used",  b_used, 0);
      check_val("zl_pass_udf",   b_underflow, 0);
      check_val("zl_pass_empty", b_rd_valid, 0);
      // Write only: visible same cycle, then held as head
      b_wr_en = 1'b1; b_wr_data = 8'h5A;
      #1;
      check_val("zl_wr_valid", b_rd_valid, 1);
      check_val("zl_wr_data",  b_rd_data, 8'h5A);
      tick();
      b_wr_en = 1'b0;
      #1;
      check_val("zl_hold_valid", b_rd_valid, 1);
      check_val("zl_hold_data",  b_rd_data, 8'h5A);
      check_val("zl_hold_used",  b_used, 1);
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      #1;
      check_val("zl_pop_used",  b_used, 0);
      check_val("zl_pop_valid", b_rd_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
